// File: rtl/add_pkg.sv
// ---------------------------------------------------------------------------
// add_pkg
// Shared definitions for the add_inverter block.
//   DEFAULT_WIDTH : default operand/result width in bits
//   result_t      : one buffered result record (recovered addend + borrow flag)
// ---------------------------------------------------------------------------
package add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // One result as held in the buffer: the recovered addend and whether the
  // subtraction that produced it wrapped (c < b).
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] a;
    logic                     borrow;
  } result_t;

endpackage

// File: rtl/add_inverter_if.sv
// ---------------------------------------------------------------------------
// add_inverter_if
// Operand/result handshake bundle for add_inverter.
//   in_valid/in_ready/c/b       : operand pair channel (producer -> block)
//   out_valid/out_ready/a/borrow: result channel (block -> consumer)
// Modports:
//   master : environment side (drives operands and out_ready)
//   slave  : block side (drives in_ready and the result channel)
// ---------------------------------------------------------------------------
interface add_inverter_if
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic             borrow;

  modport master (
    output in_valid, c, b, out_ready,
    input  in_ready, out_valid, a, borrow
  );

  modport slave (
    input  in_valid, c, b, out_ready,
    output in_ready, out_valid, a, borrow
  );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO with a combinational head read.
// Parameters:
//   W     : entry width in bits
//   DEPTH : number of entries (power of two, >= 2)
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst   : synchronous active-low reset (clears pointers and count)
//   push  : write wdata at the tail (ignored when full)
//   pop   : drop the head entry (ignored when empty)
//   wdata : entry to write
//   rdata : current head entry (meaningless when count is zero)
//   count : number of occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Guard against overflow/underflow locally so the FIFO is safe on its own,
  // independent of how the caller gates push and pop.
  assign do_push = push && (count != CNTW'(DEPTH));
  assign do_pop  = pop  && (count != '0);

  assign rdata = mem[rptr];

  // Storage carries no reset: stale entries are never visible because the
  // count says how many are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so incrementing them wraps
  // modulo DEPTH with no compare. A push and pop on the same edge moves both
  // pointers and leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + CNTW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/add_inverter.sv
// ---------------------------------------------------------------------------
// add_inverter
// Recovers the unknown addend a from a sum c and a known addend b, so that
// (a + b) mod 2^WIDTH == c, and buffers the results in a small FIFO.
// Parameters:
//   WIDTH : operand/result width in bits
//   DEPTH : result buffer entries (power of two, >= 2)
//   CW    : width of the delivered-result counter
// Ports:
//   clk        : clock, all state updates on rising edge
//   rst        : synchronous active-low reset
//   bus        : add_inverter_if slave (operand and result handshakes)
//   count      : occupied buffer entries
//   done_count : results delivered since reset, wraps at 2^CW
// ---------------------------------------------------------------------------
module add_inverter
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  add_inverter_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [CW-1:0]          done_count
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int RW   = WIDTH + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] diff;
  logic             diff_borrow;
  logic [RW-1:0]    wdata;
  logic [RW-1:0]    rdata;

  // Subtracting in WIDTH+1 bits puts the borrow in the top bit: it is set
  // exactly when c < b, and the low bits are (c - b) mod 2^WIDTH.
  assign {diff_borrow, diff} = {1'b0, bus.c} - {1'b0, bus.b};
  assign wdata               = {diff, diff_borrow};

  // Both handshake flags come only from the registered count, so a pop on a
  // full buffer cannot open a push slot in the same cycle.
  assign bus.in_ready  = (count < CNTW'(DEPTH));
  assign bus.out_valid = (count != '0);

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  sync_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count)
  );

  assign {bus.a, bus.borrow} = rdata;

  // Delivered-result counter; relies on natural CW-bit wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_count <= '0;
    end else if (pop) begin
      done_count <= done_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_add_inverter.sv
// ---------------------------------------------------------------------------
// tb_add_inverter
// Self-checking bench for add_inverter (WIDTH=4, DEPTH=2, CW=8). Inputs are
// driven and outputs sampled 1 time unit after each rising edge. A queue of
// results computed with plain integer arithmetic stands in for the buffer.
// ---------------------------------------------------------------------------
module tb_add_inverter;
  import add_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CW    = 8;

  logic                   clk;
  logic                   rst;
  logic [$clog2(DEPTH):0] count;
  logic [CW-1:0]          done_count;

  int checks = 0;
  int errors = 0;

  result_t model_q[$];
  int      model_done;

  typedef struct {
    int c;
    int b;
    int exp_a;
    int exp_borrow;
  } vec_t;

  vec_t vecs[8];

  add_inverter_if #(.WIDTH(WIDTH)) bus ();

  add_inverter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .count      (count),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a FAIL line on disagreement.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int c, input int b, input logic ready);
    bus.in_valid  = v;
    bus.c         = 4'(c);
    bus.b         = 4'(b);
    bus.out_ready = ready;
  endtask

  // Advance the reference model by the handshakes the DUT will see on the
  // coming edge, then clock the DUT and land 1 unit after the edge.
  task automatic stepClock();
    bit      do_push;
    bit      do_pop;
    int      diff;
    result_t r;
    if (!rst) begin
      model_q.delete();
      model_done = 0;
    end else begin
      do_push = bus.in_valid  && (model_q.size() < DEPTH);
      do_pop  = bus.out_ready && (model_q.size() != 0);
      if (do_pop) begin
        void'(model_q.pop_front());
        model_done = (model_done + 1) % (1 << CW);
      end
      if (do_push) begin
        diff = int'(bus.c) - int'(bus.b);
        r.borrow = (diff < 0);
        if (diff < 0) diff += (1 << WIDTH);
        r.a = 4'(diff);
        model_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".count"},      32'(count),         32'(model_q.size()));
    check({tag, ".in_ready"},   32'(bus.in_ready),  32'(model_q.size() < DEPTH));
    check({tag, ".out_valid"},  32'(bus.out_valid), 32'(model_q.size() != 0));
    check({tag, ".done_count"}, 32'(done_count),    32'(model_done));
    if (model_q.size() != 0) begin
      check({tag, ".a"},      32'(bus.a),      32'(model_q[0].a));
      check({tag, ".borrow"}, 32'(bus.borrow), 32'(model_q[0].borrow));
    end
  endtask

  initial begin
    model_done = 0;
    vecs[0] = '{3,  2,  1,  0};
    vecs[1] = '{9,  10, 15, 1};
    vecs[2] = '{5,  0,  5,  0};
    vecs[3] = '{0,  15, 1,  1};
    vecs[4] = '{0,  0,  0,  0};
    vecs[5] = '{15, 15, 0,  0};
    vecs[6] = '{0,  1,  15, 1};
    vecs[7] = '{15, 0,  15, 0};

    // Reset held low for three edges.
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) stepClock();
    check("reset.out_valid",  32'(bus.out_valid), 0);
    check("reset.in_ready",   32'(bus.in_ready),  1);
    check("reset.count",      32'(count),         0);
    check("reset.done_count", 32'(done_count),    0);
    rst = 1'b1;

    // Single pair, consumer always ready: one-cycle latency then pop.
    applyStimulus(1'b1, 3, 2, 1'b1);
    stepClock();
    check("first.out_valid", 32'(bus.out_valid), 1);
    check("first.a",         32'(bus.a),         1);
    check("first.borrow",    32'(bus.borrow),    0);
    checkOutput("first");
    applyStimulus(1'b0, 0, 0, 1'b1);
    stepClock();
    check("first.done_count", 32'(done_count), 1);
    checkOutput("first_pop");

    // Table-driven single transactions.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].c, vecs[i].b, 1'b0);
      stepClock();
      applyStimulus(1'b0, 0, 0, 1'b0);
      check($sformatf("vec%0d.a", i),      32'(bus.a),      32'(vecs[i].exp_a));
      check($sformatf("vec%0d.borrow", i), 32'(bus.borrow), 32'(vecs[i].exp_borrow));
      checkOutput($sformatf("vec%0d", i));
      applyStimulus(1'b0, 0, 0, 1'b1);
      stepClock();
      checkOutput($sformatf("vec%0d_pop", i));
    end

    // Back-pressure: three offers with consumer stalled, then drain in order.
    applyStimulus(1'b1, 1, 0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 2, 0, 1'b0);
    stepClock();
    check("bp.in_ready_full", 32'(bus.in_ready), 0);
    applyStimulus(1'b1, 3, 0, 1'b0);
    stepClock();
    check("bp.count_held", 32'(count), 2);
    check("bp.head_held",  32'(bus.a), 1);
    checkOutput("bp_held");
    applyStimulus(1'b1, 3, 0, 1'b1);
    stepClock();
    check("bp.count_after_full_pop", 32'(count), 1);
    check("bp.head2", 32'(bus.a), 2);
    checkOutput("bp_pop1");
    stepClock();
    check("bp.head3", 32'(bus.a), 3);
    checkOutput("bp_pop2");
    applyStimulus(1'b0, 0, 0, 1'b1);
    stepClock();
    checkOutput("bp_drain");

    // Reset with a full buffer and live handshakes: everything discarded.
    applyStimulus(1'b1, 7, 1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 8, 1, 1'b0);
    stepClock();
    checkOutput("prefill");
    rst = 1'b0;
    applyStimulus(1'b1, 4, 4, 1'b1);
    stepClock();
    rst = 1'b1;
    check("midrst.count",      32'(count),         0);
    check("midrst.out_valid",  32'(bus.out_valid), 0);
    check("midrst.done_count", 32'(done_count),    0);
    applyStimulus(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      check("midrst.no_stale", 32'(bus.out_valid), 0);
    end

    // Push and pop on the same edge with one entry held.
    applyStimulus(1'b1, 7, 2, 1'b0);
    stepClock();
    applyStimulus(1'b1, 9, 4, 1'b1);
    stepClock();
    check("pp.count", 32'(count), 1);
    check("pp.head",  32'(bus.a), 5);
    checkOutput("pp");
    applyStimulus(1'b0, 0, 0, 1'b1);
    stepClock();
    checkOutput("pp_drain");

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      stepClock();
      checkOutput("rand");
    end

    // done_count wrap: fresh reset, then 256 pops.
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0);
    stepClock();
    rst = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      applyStimulus(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
      stepClock();
      if (i == 255) check("wrap.done_255", 32'(done_count), 255);
    end
    check("wrap.done_0", 32'(done_count), 0);
    checkOutput("wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
